// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types, encodings and forwarding helper for hazard_unit.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Memory-stage result is younger than Writeback, so it is checked first.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       wr_m,
    input logic [4:0] rd_w,
    input logic       wr_w
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : hazard_unit
// Brief  : Forwarding, load-use / control hazard, memory-wait freeze and
//          saturating hazard statistics for the 5-stage pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int WAIT_MAX  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemTimeout,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int             c_wcw      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [c_wcw-1:0] c_wait_max = c_wcw'(WAIT_MAX);

  mem_state_e       r_state;
  logic [c_wcw-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             r_init;

  logic             w_lw_stall;
  logic             w_mem_stall;
  logic [c_wcw-1:0] w_wait_nxt;

  assign ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign w_lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // The request cycle itself already stalls; ready releases in the same cycle.
  assign w_mem_stall = (r_state == IDLE) ? (MemReqM && !MemReadyM) : !MemReadyM;

  assign w_wait_nxt = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
      r_init     <= 1'b1;
    end else begin
      r_init <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (MemReqM && !MemReadyM) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_wait_cnt <= w_wait_nxt;
          if (w_wait_nxt == c_wait_max) begin
            r_timeout <= 1'b1;
          end
          if (MemReadyM) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemTimeout = r_timeout;

  // A memory freeze must not bubble D/E: the held instructions are still live.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = w_lw_stall;
      StallD = w_lw_stall;
      FlushD = PCSrcE || r_init;
      FlushE = w_lw_stall || PCSrcE || r_init;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (StallF),
    .count(StallCount)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_flush_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (FlushE),
    .count(FlushCount)
  );

endmodule
`default_nettype wire
